// File: rtl/jtag_ahb_ap.sv
// AHB-Lite single-transfer master fed by packed JTAG AHB-AP shift words.
// Optional data-phase timeout is compiled in when AHB_AP_TIMEOUT_EN is defined.
module jtag_ahb_ap #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ADDR_RESET     = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   input  logic [36:0] req_word,
   input  logic        err_clr,
   output logic        busy,
   output logic [31:0] rdata,
   output logic [31:0] addr,
   output logic [3:0]  status,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   typedef enum logic [1:0] {StIdle, StAddrPh, StDataPh} state_t;

   state_t      r_state, w_state_d;
   logic [31:0] r_addr, w_addr_d;
   logic [31:0] r_rdata, w_rdata_d;
   logic [31:0] r_wdata;
   logic [3:0]  r_status, w_set;
   logic [1:0]  r_size;
   logic        r_write, r_inc;
   logic        w_latch, w_misalign, w_tmo;
   logic [31:0] w_inc_amt;

   // ap_shift_t: {data, regselect, size, addrinc, r_w}; regselect 0 = ADDRESS, 1 = DATA
   logic [31:0] w_req_data;
   logic        w_req_regsel, w_req_inc, w_req_rw;
   logic [1:0]  w_req_size;

   assign w_req_data   = req_word[36:5];
   assign w_req_regsel = req_word[4];
   assign w_req_size   = req_word[3:2];
   assign w_req_inc    = req_word[1];
   assign w_req_rw     = req_word[0];
   assign w_inc_amt    = 32'd1 << r_size;

`ifdef AHB_AP_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tcnt;

   assign w_tmo = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_tcnt <= '0;
      end else if (r_state == StAddrPh) begin
         r_tcnt <= '0;
      end else if ((r_state == StDataPh) && !HREADY) begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end
`else
   // Timeout disabled: the data phase waits on HREADY indefinitely.
   assign w_tmo = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      w_misalign = 1'b1;
      case (w_req_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = r_addr[0];
         2'b10:   w_misalign = |r_addr[1:0];
         default: w_misalign = 1'b1;
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      w_addr_d  = r_addr;
      w_rdata_d = r_rdata;
      w_set     = 4'b0000;
      w_latch   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (req_valid) begin
               if (!w_req_regsel) begin
                  w_addr_d = w_req_data;
               end else if (w_misalign) begin
                  w_set[2] = 1'b1;
               end else begin
                  w_latch   = 1'b1;
                  w_state_d = StAddrPh;
               end
            end
         end
         StAddrPh: begin
            if (HREADY) w_state_d = StDataPh;
         end
         StDataPh: begin
            if (HREADY) begin
               w_state_d = StIdle;
               if (HRESP) begin
                  w_set[1] = 1'b1;
               end else begin
                  if (!r_write) w_rdata_d = HRDATA;
                  if (r_inc) w_addr_d = r_addr + w_inc_amt;
               end
            end else if (w_tmo) begin
               w_state_d = StIdle;
               w_set[3]  = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
      if (req_valid && (r_state != StIdle)) w_set[0] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= StIdle;
         r_addr   <= ADDR_RESET;
         r_rdata  <= 32'h0;
         r_status <= 4'h0;
         r_size   <= 2'b00;
         r_write  <= 1'b0;
         r_inc    <= 1'b0;
         r_wdata  <= 32'h0;
      end else begin
         r_state  <= w_state_d;
         r_addr   <= w_addr_d;
         r_rdata  <= w_rdata_d;
         // A new error event wins over a simultaneous clear.
         r_status <= (r_status & ~{4{err_clr}}) | w_set;
         if (w_latch) begin
            r_size  <= w_req_size;
            r_write <= w_req_rw;
            r_inc   <= w_req_inc;
            r_wdata <= w_req_data;
         end
      end
   end

   assign busy   = (r_state != StIdle);
   assign rdata  = r_rdata;
   assign addr   = r_addr;
   assign status = r_status;
   assign HTRANS = (r_state == StAddrPh) ? 2'b10 : 2'b00;
   assign HADDR  = (r_state == StAddrPh) ? r_addr : 32'h0;
   assign HWRITE = (r_state == StAddrPh) && r_write;
   assign HSIZE  = (r_state == StAddrPh) ? {1'b0, r_size} : 3'b000;
   assign HWDATA = ((r_state == StDataPh) && r_write) ? r_wdata : 32'h0;

endmodule

// File: doc/jtag_ahb_ap.md
Name: jtag_ahb_ap

Overview:
AHB-Lite master access port behind the JTAG AHB instruction. Consumes a packed ap_shift_t word (data, regselect, size, addrinc, r_w) delivered once per UPDATE_DR. Loads the address register or executes a single AHB-Lite read or write. Returns read data and sticky status for the next CAPTURE_DR. Sits directly downstream of the AHB data-register shift chain, in the system clock domain.

Parameters:
TIMEOUT_CYCLES, 1024, maximum HREADY-low cycles in the data phase before abort (only with AHB_AP_TIMEOUT_EN).
ADDR_RESET, 32'h0000_0000, reset value of the address register.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  asynchronous, active-high reset.
req_valid  input  1  one-cycle pulse: req_word is valid.
req_word  input  37  ap_shift_t {data[31:0], regselect, size[1:0], addrinc, r_w}.
err_clr  input  1  clears all sticky error flags.
busy  output  1  transaction in progress.
rdata  output  32  last completed read data.
addr  output  32  current address register.
status  output  4  {timeout_err, align_err, bus_err, overrun}, all sticky.
HADDR  output  32  AHB address.
HTRANS  output  2  2'b00 IDLE / 2'b10 NONSEQ only.
HWRITE  output  1  AHB write.
HSIZE  output  3  {1'b0, size}.
HWDATA  output  32  AHB write data.
HRDATA  input  32  AHB read data.
HREADY  input  1  AHB ready.
HRESP  input  1  AHB error response.

Behaviour:
- Reset values:
  - busy=0, rdata=0, addr=ADDR_RESET, status=0.
  - HTRANS=IDLE, HWRITE=0, HSIZE=0, HADDR=0, HWDATA=0.
  - FSM=IDLE.
- FSM states are IDLE, ADDR_PH, DATA_PH.
- IDLE, on req_valid:
  - regselect=ADDRESS: addr<=data next cycle; no bus activity; busy stays 0.
  - regselect=DATA, address misaligned for size (HALFWORD with addr[0]=1, or WORD with addr[1:0]!=0): no transfer; align_err<=1; addr not incremented.
  - regselect=DATA, aligned: latch size, r_w and data; go to ADDR_PH; busy<=1.
  - size=2'b11 is treated as a misaligned access and sets align_err.
- ADDR_PH:
  - Drive HTRANS=NONSEQ, HADDR=addr, HWRITE=r_w, HSIZE.
  - Hold all until HREADY=1, then go to DATA_PH.
- DATA_PH:
  - Drive HTRANS=IDLE. On a write, HWDATA=latched data.
  - On HREADY=1 with HRESP=0: on a read, rdata<=HRDATA. If addrinc=1, addr<=addr+{1,2,4} by size, wrapping modulo 2^32. Go to IDLE; busy<=0.
  - On HREADY=1 with HRESP=1: bus_err<=1; rdata unchanged; addr not incremented; go to IDLE.
- Latency: an aligned access with zero wait states asserts busy for 2 cycles. rdata is valid the cycle busy falls.
- req_valid while busy=1: request dropped; overrun<=1; transaction in flight unaffected.
- err_clr and a new error event in the same cycle: the set wins.
- RST mid-transaction: immediate return to reset values. A possibly truncated bus transfer is acceptable; the slave is reset with the system.
- Only one outstanding transfer exists. HTRANS never takes BUSY or SEQ.

Optional Feature:
AHB_AP_TIMEOUT_EN:
- Defined: a counter runs while in DATA_PH with HREADY=0. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, timeout_err<=1, busy<=0, rdata and addr are unchanged. The counter clears on entry to DATA_PH.
- Undefined: no counter; DATA_PH waits indefinitely; timeout_err is tied to 0.

Test Plan:
- ADDRESS req data=32'h2000_0010, then DATA write data=32'hDEAD_BEEF, size=WORD, addrinc=1, zero-wait slave -> one NONSEQ at 0x2000_0010, HWDATA=DEAD_BEEF, busy high 2 cycles, addr=0x2000_0014.
- addr=0x100, read HALFWORD addrinc=1, slave inserts 3 wait states returning 32'h0000_1234 -> rdata=0x0000_1234, busy high 5 cycles, addr=0x102.
- addr=0x101, WORD write -> no HTRANS NONSEQ, status=4'b0100, addr=0x101; err_clr -> status=0.
- Slave returns HRESP=1 on read at 0x40 with addrinc=1 -> bus_err=1, rdata unchanged, addr=0x40.
- Second req_valid during a wait-stated write -> overrun=1; first write completes normally, exactly one transfer seen.
- addr=32'hFFFF_FFFC, WORD write with addrinc -> addr wraps to 0. With AHB_AP_TIMEOUT_EN and TIMEOUT_CYCLES=8, HREADY held low -> timeout_err=1, busy falls after 8 data-phase cycles.
